// File: rtl/noc_pkg.sv
// Shared NoC packet definitions: field geometry of the 32-bit packet and its struct view.
package noc_pkg;

    localparam int PKT_W          = 32;
    localparam int DEST_W         = 8;
    localparam int PAYLOAD_W      = 24;
    localparam int DEST_MSB       = 31;
    localparam int DEST_LSB       = 24;
    localparam int NUM_PE_DEFAULT = 16;

    typedef struct packed {
        logic [DEST_W-1:0]    dest;
        logic [PAYLOAD_W-1:0] payload;
    } noc_pkt_t;

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers wrap naturally (DEPTH is a
// power of two); occupancy lives in its own counter so full/empty come from flops.
module noc_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rdata,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Zero when empty so nothing stale is ever presented after reset.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pe_inject_buffer.sv
// PE-to-router injection buffer: FIFO with destination screening and drop reporting.
// Optional INJECT_STATS_EN adds saturating accept/send counters.
module pe_inject_buffer
    import noc_pkg::*;
#(
    parameter int ADDRESS = 0,
    parameter int DEPTH   = 8,
    parameter int NUM_PE  = NUM_PE_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PKT_W-1:0]           i_data,
    input  logic                       i_data_valid,
    output logic                       o_data_ready,
    output logic [PKT_W-1:0]           o_data,
    output logic                       o_data_valid,
    input  logic                       i_data_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_drop,
    output logic [DEST_W-1:0]          o_drop_dest
`ifdef INJECT_STATS_EN
    ,
    output logic [31:0]                o_sent_cnt,
    output logic [31:0]                o_acc_cnt
`endif
);

    // Reject configurations the pointer arithmetic and id field cannot represent.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pe_inject_buffer: DEPTH must be a power of two >= 2");
    end
    if (ADDRESS < 0 || ADDRESS >= (1 << DEST_W)) begin : g_bad_addr
        $error("pe_inject_buffer: ADDRESS does not fit the dest field");
    end

    noc_pkt_t in_pkt;
    logic     full;
    logic     empty;
    logic     accept;
    logic     legal;
    logic     pop;

    assign in_pkt       = i_data;
    assign legal        = (32'(in_pkt.dest) < NUM_PE);
    // Ready depends only on registered occupancy, never on i_data_ready.
    assign o_data_ready = !full;
    assign o_data_valid = !empty;
    assign accept       = i_data_valid && o_data_ready;
    assign pop          = o_data_valid && i_data_ready;

    noc_sync_fifo #(.DATA_W(PKT_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept && legal),
        .wdata (in_pkt),
        .pop   (pop),
        .rdata (o_data),
        .level (o_level),
        .full  (full),
        .empty (empty)
    );

    // One-cycle drop pulse; the dest field of the last discard is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_drop      <= 1'b0;
            o_drop_dest <= '0;
        end else begin
            o_drop <= accept && !legal;
            if (accept && !legal) o_drop_dest <= in_pkt.dest;
        end
    end

`ifdef INJECT_STATS_EN
    // Saturating counters of router pops and PE accepts (legal or dropped).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_sent_cnt <= '0;
            o_acc_cnt  <= '0;
        end else begin
            if (pop && o_sent_cnt != '1)   o_sent_cnt <= o_sent_cnt + 32'd1;
            if (accept && o_acc_cnt != '1) o_acc_cnt  <= o_acc_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_inject_buffer.sv
// Directed bench for pe_inject_buffer (DEPTH=8, NUM_PE=16); INJECT_STATS_EN adds the counter test.
module tb_pe_inject_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_data;
    logic        i_data_valid;
    logic        o_data_ready;
    logic [31:0] o_data;
    logic        o_data_valid;
    logic        i_data_ready;
    logic [3:0]  o_level;
    logic        o_drop;
    logic [7:0]  o_drop_dest;
`ifdef INJECT_STATS_EN
    logic [31:0] o_sent_cnt;
    logic [31:0] o_acc_cnt;
`endif

    pe_inject_buffer #(.ADDRESS(0), .DEPTH(8), .NUM_PE(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_data_ready (o_data_ready),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .i_data_ready (i_data_ready),
        .o_level      (o_level),
        .o_drop       (o_drop),
        .o_drop_dest  (o_drop_dest)
`ifdef INJECT_STATS_EN
        ,
        .o_sent_cnt   (o_sent_cnt),
        .o_acc_cnt    (o_acc_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          lvl_m  = 0;
    int          drop_n = 0;
    int          peak   = 0;
    int          d0;
    logic [31:0] pe_q[$];
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock: PE offers the head of pe_q, router ready = rr; model checks outputs after the edge.
    task automatic cycle(input logic rr);
        logic        acc, pop, stall, legal;
        logic [31:0] pk, head, want;
        i_data_ready = rr;
        i_data_valid = (pe_q.size() != 0);
        i_data       = (pe_q.size() != 0) ? pe_q[0] : 32'h0;
        acc   = i_data_valid && o_data_ready;
        pop   = o_data_valid && rr;
        stall = o_data_valid && !rr;
        head  = o_data;
        pk    = i_data;
        tick();
        if (pop) begin
            want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            chk("pop_order", head, want);
            lvl_m--;
        end
        if (stall) chk("stall_hold", o_data, head);
        legal = (pk[31:24] < 8'd16);
        if (acc) begin
            void'(pe_q.pop_front());
            if (legal) begin
                exp_q.push_back(pk);
                lvl_m++;
            end
        end
        chk("drop_pulse", 32'(o_drop), 32'(acc && !legal));
        if (acc && !legal) begin
            chk("drop_dest", 32'(o_drop_dest), 32'(pk[31:24]));
            drop_n++;
        end
        chk("level", 32'(o_level), lvl_m);
        if (lvl_m > peak) peak = lvl_m;
`ifdef INJECT_STATS_EN
        chk("stats_inv", o_acc_cnt - o_sent_cnt - 32'(drop_n), 32'(o_level));
`endif
    endtask

    // Synchronous-release reset sequence; model state is cleared with the DUT.
    task automatic do_reset();
        i_data_valid = 1'b0;
        i_data       = 32'h0;
        rst          = 1'b1;
        pe_q.delete();
        exp_q.delete();
        lvl_m  = 0;
        drop_n = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst          = 1'b1;
        i_data       = 32'h0;
        i_data_valid = 1'b0;
        i_data_ready = 1'b0;
        #2;
        chk("rst_level", 32'(o_level), 0);
        chk("rst_valid", 32'(o_data_valid), 0);
        chk("rst_data", o_data, 32'h0);
        chk("rst_drop", 32'(o_drop), 0);
        chk("rst_drop_dest", 32'(o_drop_dest), 0);
        chk("rst_ready", 32'(o_data_ready), 1);
        tick();
        rst = 1'b0;
        tick();

        // T1: three packets straight through; first valid one cycle after accept.
        i_data       = 32'h0500_0001;
        i_data_valid = 1'b1;
        i_data_ready = 1'b1;
        tick();
        chk("t1_latency_valid", 32'(o_data_valid), 1);
        chk("t1_first_data", o_data, 32'h0500_0001);
        chk("t1_level", 32'(o_level), 1);
        exp_q.push_back(32'h0500_0001);
        lvl_m = 1;
        pe_q.push_back(32'h0500_0002);
        pe_q.push_back(32'h0500_0003);
        repeat (4) cycle(1'b1);
        chk("t1_empty_level", 32'(o_level), 0);
        chk("t1_empty_valid", 32'(o_data_valid), 0);

        // T2: router stalled while PE streams 10 packets.
        for (int k = 1; k <= 10; k++) pe_q.push_back(32'h0100_0000 | 32'(k));
        repeat (8) cycle(1'b0);
        chk("t2_full_level", 32'(o_level), 8);
        chk("t2_full_ready", 32'(o_data_ready), 0);
        repeat (2) cycle(1'b0);
        chk("t2_pe_waiting", 32'(pe_q.size()), 2);
        for (int c = 0; c < 30 && (pe_q.size() + exp_q.size()) != 0; c++) cycle(1'b1);
        chk("t2_drained", 32'(pe_q.size() + exp_q.size()), 0);
        chk("t2_level", 32'(o_level), 0);

        // T3: illegal dest 0x10 dropped, legal 0x0F forwarded.
        d0   = drop_n;
        peak = 0;
        pe_q.push_back(32'h1000_0077);
        pe_q.push_back(32'h0F00_0055);
        cycle(1'b0);
        chk("t3_drop_seen", 32'(o_drop), 1);
        chk("t3_drop_dest", 32'(o_drop_dest), 32'h10);
        cycle(1'b0);
        repeat (3) cycle(1'b1);
        chk("t3_drop_once", 32'(drop_n - d0), 1);
        chk("t3_peak", 32'(peak), 1);
        chk("t3_drop_dest_held", 32'(o_drop_dest), 32'h10);

        // T4: full buffer, router ready toggling, PE always valid.
        for (int k = 0; k < 28; k++) pe_q.push_back(32'h0200_0100 | 32'(k));
        repeat (8) cycle(1'b0);
        chk("t4_full", 32'(o_level), 8);
        for (int c = 0; c < 20; c++) begin
            cycle((c % 2) == 0);
            chk("t4_band", 32'(o_level >= 4'd7 && o_level <= 4'd8), 1);
        end
        for (int c = 0; c < 40 && (pe_q.size() + exp_q.size()) != 0; c++) cycle(1'b1);
        chk("t4_drained", 32'(pe_q.size() + exp_q.size()), 0);

        // T5: async reset with 5 packets buffered.
        for (int k = 0; k < 5; k++) pe_q.push_back(32'h0400_0000 | 32'(k));
        repeat (5) cycle(1'b0);
        chk("t5_level5", 32'(o_level), 5);
        i_data_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("t5_async_valid", 32'(o_data_valid), 0);
        chk("t5_async_level", 32'(o_level), 0);
        pe_q.delete();
        exp_q.delete();
        lvl_m  = 0;
        drop_n = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        pe_q.push_back(32'h0300_00AA);
        cycle(1'b1);
        chk("t5_first_after_rst", o_data, 32'h0300_00AA);
        repeat (2) cycle(1'b1);
        chk("t5_empty", 32'(o_level), 0);

`ifdef INJECT_STATS_EN
        // T6: 100 packets, 4 illegal, random router backpressure.
        do_reset();
        chk("t6_rst_acc", o_acc_cnt, 0);
        chk("t6_rst_sent", o_sent_cnt, 0);
        for (int k = 0; k < 100; k++) begin
            if ((k % 25) == 7) pe_q.push_back(32'hF000_0000 | 32'(k));
            else               pe_q.push_back({8'(k % 16), 24'(k)});
        end
        for (int c = 0; c < 800 && (pe_q.size() + exp_q.size()) != 0; c++)
            cycle(1'($urandom_range(0, 1)));
        chk("t6_drained", 32'(pe_q.size() + exp_q.size()), 0);
        chk("t6_acc_cnt", o_acc_cnt, 100);
        chk("t6_sent_cnt", o_sent_cnt, 96);
        chk("t6_drops", 32'(drop_n), 4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
